// File: rtl/iob_burst_rd_pkg.sv
// Shared state encoding and buffer depth for the burst read stage.
package iob_burst_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } brd_state_e;

  localparam int unsigned BRD_FIFO_DEPTH = 2;

endpackage

// File: rtl/iob_burst_rd_fifo2.sv
// Two-entry register FIFO; the head register is the output, so dout only changes on pop or first push.
module iob_burst_rd_fifo2
  import iob_burst_rd_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [1:0]        cnt_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop_eff;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    pop_eff = pop_i && (cnt_q != 2'd0);
    case ({push_i, pop_eff})
      2'b10: begin
        // A push into a full buffer is dropped; the issue rule upstream never lets it happen.
        if (cnt_q < 2'(BRD_FIFO_DEPTH)) begin
          if (cnt_q == 2'd0) head_d = din_i;
          else               tail_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o = head_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/iob_2p_mem_burst_rd.sv
// Turns (start address, length) into sequential memory reads streamed out as valid/ready words.
// Optional macro IOB_BURST_RD_STALL_CNT_EN adds a saturating stall_cnt_o output.
module iob_2p_mem_burst_rd
  import iob_burst_rd_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 8192,
  parameter int ADDR_W  = $clog2(N_WORDS),
  parameter int LEN_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_r_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
`ifdef IOB_BURST_RD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  brd_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic              issue;
  logic              pop;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occupancy;
  logic [ADDR_W-1:0] addr_next;

  assign pop       = m_valid_o && m_ready_i;
  // Words already owed to the buffer after this cycle's pop; a new read must still fit.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign addr_next = (addr_q == ADDR_W'(N_WORDS - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_d  = start_addr_i;
            rem_d   = len_i;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        issue = (rem_q != '0) && (occupancy < 3'(BRD_FIFO_DEPTH));
        if (issue) begin
          addr_d     = addr_next;
          rem_d      = rem_q - LEN_W'(1);
          inflight_d = 1'b1;
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (fifo_cnt == 2'd1) && pop) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  iob_burst_rd_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push_i(inflight_q),
    .pop_i (pop),
    .din_i (mem_data_out_i),
    .dout_o(m_data_o),
    .cnt_o (fifo_cnt)
  );

  assign m_valid_o  = (fifo_cnt != 2'd0);
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign mem_r_en_o = issue;
  assign mem_addr_o = addr_q;

`ifdef IOB_BURST_RD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start_i) begin
      stall_cnt_d = '0;
    end else if (busy_o && m_valid_o && !m_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
